// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding selects and load-use stall from a private post-EX history
module fwd_hazard_unit #(
  parameter int DEPTH = 2,
  parameter int LOAD_READY = 2,
  parameter int AW = 5,
  parameter int CNT_W = 16,
  localparam int FW_W = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            hold_i,
  input  logic            flush_i,
  input  logic [AW-1:0]   id_rs_i,
  input  logic [AW-1:0]   id_rt_i,
  input  logic [AW-1:0]   ex_rs_i,
  input  logic [AW-1:0]   ex_rt_i,
  input  logic            ex_regwrite_i,
  input  logic            ex_memread_i,
  input  logic [AW-1:0]   ex_regdst_i,
  output logic [FW_W-1:0] forward_1_o,
  output logic [FW_W-1:0] forward_2_o,
  output logic            stall_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic            hazard_err_o
);
  logic [DEPTH:1] h_valid, h_rw, h_mr;
  logic [AW-1:0]  h_dst [1:DEPTH];
  logic           ld_a, ld_b, err_now;
  assign ld_a = LOAD_READY > 1 && ex_memread_i && ex_regwrite_i && ex_regdst_i != '0 &&
                (ex_regdst_i == id_rs_i || ex_regdst_i == id_rt_i);
  assign stall_o = !flush_i && (ld_a || ld_b);
  // Scan oldest to youngest so the youngest matching producer is the one left standing.
  always_comb begin
    forward_1_o = '0;
    forward_2_o = '0;
    ld_b = 1'b0;
    err_now = 1'b0;
    for (int j = DEPTH; j >= 1; j--) begin
      if (h_valid[j] && h_rw[j] && h_dst[j] != '0 && h_dst[j] == ex_rs_i) forward_1_o = FW_W'(j);
      if (h_valid[j] && h_rw[j] && h_dst[j] != '0 && h_dst[j] == ex_rt_i) forward_2_o = FW_W'(j);
      if (j <= LOAD_READY - 2 && h_valid[j] && h_rw[j] && h_mr[j] && h_dst[j] != '0 &&
          (h_dst[j] == id_rs_i || h_dst[j] == id_rt_i)) ld_b = 1'b1;
    end
    for (int j = 1; j <= DEPTH; j++)
      if (j < LOAD_READY && h_mr[j] && (forward_1_o == FW_W'(j) || forward_2_o == FW_W'(j))) err_now = 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      h_valid <= '0;
      h_rw <= '0;
      h_mr <= '0;
      for (int j = 1; j <= DEPTH; j++) h_dst[j] <= '0;
      stall_cnt_o <= '0;
      hazard_err_o <= 1'b0;
    end else if (!hold_i) begin
      for (int j = DEPTH; j >= 2; j--) begin
        h_valid[j] <= h_valid[j-1];
        h_rw[j] <= h_rw[j-1];
        h_mr[j] <= h_mr[j-1];
        h_dst[j] <= h_dst[j-1];
      end
      h_valid[1] <= !flush_i;
      h_rw[1] <= ex_regwrite_i;
      h_mr[1] <= ex_memread_i;
      h_dst[1] <= ex_regdst_i;
      if (stall_o && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      hazard_err_o <= hazard_err_o | err_now;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: two configurations (2/2 and 3/3) checked against a queue-based history model
module tb_fwd_hazard_unit;
  logic clk_i = 1'b0, rst_i = 1'b0, hold_i = 1'b0, flush_i = 1'b0;
  logic [4:0] id_rs_i = '0, id_rt_i = '0, ex_rs_i = '0, ex_rt_i = '0, ex_regdst_i = '0;
  logic ex_regwrite_i = 1'b0, ex_memread_i = 1'b0;
  logic [1:0] f1_a, f2_a, f1_b, f2_b;
  logic st_a, st_b, err_a, err_b;
  logic [15:0] cnt_a, cnt_b;
  int vectors = 0, miscompares = 0;
  typedef struct {bit v; bit rw; bit mr; bit [4:0] d;} rec_t;
  rec_t hist[$];
  int dep[2] = '{2, 3};
  int lr[2] = '{2, 3};
  int m_cnt[2];
  bit m_err[2];

  always #5 clk_i = ~clk_i;

  fwd_hazard_unit u_a (
    .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .ex_rs_i(ex_rs_i), .ex_rt_i(ex_rt_i),
    .ex_regwrite_i(ex_regwrite_i), .ex_memread_i(ex_memread_i), .ex_regdst_i(ex_regdst_i),
    .forward_1_o(f1_a), .forward_2_o(f2_a), .stall_o(st_a), .stall_cnt_o(cnt_a), .hazard_err_o(err_a));

  fwd_hazard_unit #(.DEPTH(3), .LOAD_READY(3)) u_b (
    .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .ex_rs_i(ex_rs_i), .ex_rt_i(ex_rt_i),
    .ex_regwrite_i(ex_regwrite_i), .ex_memread_i(ex_memread_i), .ex_regdst_i(ex_regdst_i),
    .forward_1_o(f1_b), .forward_2_o(f2_b), .stall_o(st_b), .stall_cnt_o(cnt_b), .hazard_err_o(err_b));

  function automatic bit wr(int j, bit [4:0] r);
    if (j > hist.size()) return 1'b0;
    return hist[j-1].v && hist[j-1].rw && hist[j-1].d == r && r != 0;
  endfunction

  function automatic int fsel(int k, bit [4:0] r);
    for (int j = 1; j <= dep[k]; j++) if (wr(j, r)) return j;
    return 0;
  endfunction

  function automatic bit mstall(int k);
    bit b = 1'b0;
    for (int j = 1; j <= lr[k] - 2; j++)
      if (j <= hist.size() && hist[j-1].mr && (wr(j, id_rs_i) || wr(j, id_rt_i))) b = 1'b1;
    return !flush_i && (b || (lr[k] > 1 && ex_memread_i && ex_regwrite_i && ex_regdst_i != 0 &&
                              (ex_regdst_i == id_rs_i || ex_regdst_i == id_rt_i)));
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drv(bit fl, bit ho, bit [4:0] irs, bit [4:0] irt, bit [4:0] ers, bit [4:0] ert,
                     bit rw, bit mr, bit [4:0] d);
    flush_i = fl; hold_i = ho; id_rs_i = irs; id_rt_i = irt; ex_rs_i = ers; ex_rt_i = ert;
    ex_regwrite_i = rw; ex_memread_i = mr; ex_regdst_i = d;
    #1;
  endtask

  task automatic step();
    int s1[2], s2[2];
    bit st[2];
    #1;
    for (int k = 0; k < 2; k++) begin
      s1[k] = fsel(k, ex_rs_i);
      s2[k] = fsel(k, ex_rt_i);
      st[k] = mstall(k);
    end
    chk("fwd1_a", 32'(f1_a), s1[0]); chk("fwd2_a", 32'(f2_a), s2[0]); chk("stall_a", 32'(st_a), 32'(st[0]));
    chk("fwd1_b", 32'(f1_b), s1[1]); chk("fwd2_b", 32'(f2_b), s2[1]); chk("stall_b", 32'(st_b), 32'(st[1]));
    @(posedge clk_i);
    if (!hold_i) begin
      for (int k = 0; k < 2; k++) begin
        if (st[k] && m_cnt[k] < 65535) m_cnt[k]++;
        if ((s1[k] > 0 && s1[k] < lr[k] && hist[s1[k]-1].mr) ||
            (s2[k] > 0 && s2[k] < lr[k] && hist[s2[k]-1].mr)) m_err[k] = 1'b1;
      end
      hist.push_front(rec_t'{!flush_i, ex_regwrite_i, ex_memread_i, ex_regdst_i});
      if (hist.size() > 4) void'(hist.pop_back());
    end
    #1;
    chk("cnt_a", 32'(cnt_a), m_cnt[0]); chk("err_a", 32'(err_a), 32'(m_err[0]));
    chk("cnt_b", 32'(cnt_b), m_cnt[1]); chk("err_b", 32'(err_b), 32'(m_err[1]));
  endtask

  task automatic async_rst();
    #2 rst_i = 1'b0;
    hist.delete();
    m_cnt = '{0, 0};
    m_err = '{0, 0};
    #1;
    chk("rst_fwd1_a", 32'(f1_a), 0); chk("rst_fwd2_a", 32'(f2_a), 0);
    chk("rst_fwd1_b", 32'(f1_b), 0); chk("rst_fwd2_b", 32'(f2_b), 0);
    chk("rst_cnt_a", 32'(cnt_a), 0); chk("rst_err_a", 32'(err_a), 0);
    chk("rst_cnt_b", 32'(cnt_b), 0); chk("rst_err_b", 32'(err_b), 0);
    chk("rst_stall_a", 32'(st_a), 32'(mstall(0))); chk("rst_stall_b", 32'(st_b), 32'(mstall(1)));
    rst_i = 1'b1;
  endtask

  initial begin
    #2;
    chk("init_fwd1", 32'(f1_a), 0); chk("init_fwd2", 32'(f2_a), 0);
    chk("init_cnt", 32'(cnt_a), 0); chk("init_err", 32'(err_a), 0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    // RAW distance: select 1, 2, then 0 once the producer ages out of a 2-deep history
    drv(0, 0, 0, 0, 0, 0, 1, 0, 3); step();
    drv(0, 0, 0, 0, 3, 0, 1, 0, 9); chk("raw_d1", 32'(f1_a), 1); step();
    drv(0, 0, 0, 0, 3, 0, 1, 0, 10); chk("raw_d2", 32'(f1_a), 2); step();
    drv(0, 0, 0, 0, 3, 3, 0, 0, 0); chk("raw_d3", 32'(f1_a), 0); chk("raw_d3_b", 32'(f2_b), 3); step();
    // Youngest producer wins; r0 never forwards
    drv(0, 0, 0, 0, 0, 0, 1, 0, 7); step();
    drv(0, 0, 0, 0, 0, 0, 1, 0, 7); step();
    drv(0, 0, 0, 0, 7, 7, 1, 0, 0); chk("prio_1", 32'(f1_a), 1); chk("prio_2", 32'(f2_a), 1); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); chk("r0", 32'(f1_a), 0); step();
    // Load-use with LOAD_READY=2
    async_rst();
    drv(0, 0, 5, 0, 0, 0, 1, 1, 5); chk("lu_stall1", 32'(st_a), 1); step();
    drv(0, 0, 5, 0, 0, 0, 0, 0, 0); chk("lu_stall2", 32'(st_a), 0); step();
    drv(0, 0, 0, 0, 5, 0, 1, 0, 8); chk("lu_fwd", 32'(f1_a), 2); chk("lu_cnt", 32'(cnt_a), 1); step();
    chk("lu_err", 32'(err_a), 0);
    // Load-use with LOAD_READY=3, DEPTH=3
    async_rst();
    drv(0, 0, 5, 0, 0, 0, 1, 1, 5); chk("lu3_s1", 32'(st_b), 1); step();
    drv(0, 0, 5, 0, 0, 0, 0, 0, 0); chk("lu3_s2", 32'(st_b), 1); step();
    drv(0, 0, 5, 0, 0, 0, 0, 0, 0); chk("lu3_s3", 32'(st_b), 0); step();
    drv(0, 0, 0, 0, 5, 0, 1, 0, 8); chk("lu3_fwd", 32'(f1_b), 3); chk("lu3_cnt", 32'(cnt_b), 2); step();
    // Hold during a stall freezes history and counter
    async_rst();
    drv(0, 0, 0, 0, 0, 0, 1, 0, 12); step();
    repeat (3) begin
      drv(0, 1, 5, 0, 12, 0, 1, 1, 5); chk("hold_stall", 32'(st_a), 1); chk("hold_fwd", 32'(f1_a), 1); step();
    end
    chk("hold_cnt", 32'(cnt_a), 0);
    drv(0, 0, 5, 0, 0, 0, 1, 1, 5); step();
    chk("unhold_cnt", 32'(cnt_a), 1);
    // Flush kills the stall and the flushed producer
    async_rst();
    drv(1, 0, 5, 0, 0, 0, 1, 1, 5); chk("flush_st_a", 32'(st_a), 0); chk("flush_st_b", 32'(st_b), 0); step();
    drv(0, 0, 0, 0, 5, 5, 0, 0, 0); chk("flush_fwd_a", 32'(f1_a), 0); chk("flush_fwd_b", 32'(f2_b), 0); step();
    chk("flush_cnt", 32'(cnt_a), 0);
    // Bubble-free load-use trips the sticky error
    async_rst();
    drv(0, 0, 0, 0, 0, 0, 1, 1, 6); step();
    drv(0, 0, 0, 0, 6, 0, 1, 0, 9); chk("err_fwd", 32'(f1_a), 1); step();
    chk("err_set", 32'(err_a), 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("err_sticky", 32'(err_a), 1);
    async_rst();
    // Randomised traffic on a small register set for frequent matches
    for (int i = 0; i < 400; i++) begin
      drv($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)));
      step();
      if (i % 50 == 49) async_rst();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised operand-forwarding and load-use hazard unit for the pipelined MIPS core, sitting beside the ID/EX boundary. It keeps its own DEPTH-entry history of the destination registers leaving EX, so the pipeline no longer routes MEM/WB destination buses to it. Every cycle it produces per-operand forward selects for the instruction in EX and a load-use stall for the instruction in ID. It also keeps a saturating stall-cycle counter and a sticky hazard-error flag for verification and performance analysis.

## Interface
Parameters:
- DEPTH, 2: number of post-EX history entries that can forward; entry 1 = MEM, entry 2 = WB, and so on.
- LOAD_READY, 2: lowest history index at which load data can be forwarded; legal range 1..DEPTH.
- AW, 5: register-address width.
- CNT_W, 16: stall-counter width.
- FW_W (localparam): clog2(DEPTH+1), the width of each forward select.

Ports:
- clk_i, in, 1: clock; all state updates on the rising edge.
- rst_i, in, 1: asynchronous, active-low reset.
- hold_i, in, 1: whole-pipeline freeze (memory stall); history and counter hold their values.
- flush_i, in, 1: ID and EX instructions are being killed this cycle.
- id_rs_i, in, AW: rs of the instruction in ID.
- id_rt_i, in, AW: rt of the instruction in ID.
- ex_rs_i, in, AW: rs of the instruction in EX.
- ex_rt_i, in, AW: rt of the instruction in EX.
- ex_regwrite_i, in, 1: the EX instruction writes a register.
- ex_memread_i, in, 1: the EX instruction is a load.
- ex_regdst_i, in, AW: destination register of the EX instruction.
- forward_1_o, out, FW_W: source select for the rs operand; 0 = register file, j = history entry j.
- forward_2_o, out, FW_W: source select for the rt operand; same encoding.
- stall_o, out, 1: freeze PC and IF/ID, and bubble ID/EX.
- stall_cnt_o, out, CNT_W: number of stall cycles taken.
- hazard_err_o, out, 1: sticky flag set when an operand is forwarded from a load that is not yet ready.

## Operation
- History entry fields: valid, regwrite, memread, dst. The entry "writes r" when valid && regwrite && dst == r && r != 0.
- Shift rule: on each non-hold edge, entry j takes entry j-1 for j = 2..DEPTH. Entry 1 takes the EX inputs, with valid = !flush_i. Entry DEPTH is discarded.
- Register-file contract: the register file is write-before-read, so producers older than entry DEPTH are always visible through it.
- Forward selection (forward_1_o from ex_rs_i, forward_2_o from ex_rt_i):
  - Output the smallest j in 1..DEPTH whose entry writes the source register; output 0 if none.
  - The youngest producer wins.
  - r0 is never forwarded and always yields 0.
- Load-use stall: stall_o = !flush_i && (A || B), where
  - A: ex_memread_i && ex_regwrite_i && ex_regdst_i != 0 && ex_regdst_i ∈ {id_rs_i, id_rt_i}, and LOAD_READY > 1.
  - B: some entry j, 1 ≤ j ≤ LOAD_READY-2, is valid && memread and writes id_rs_i or id_rt_i.
  - Meaning: the ID consumer may advance only if, once it reaches EX, its load producer sits at index ≥ LOAD_READY.
- Stall side effects: the unit does not insert the bubble itself. The external ID/EX register zeroes its control bits, so the bubble arrives back on the ex_* inputs and enters history as a non-writing entry.
- hold_i does not mask stall_o.
- stall_cnt_o: increments on each edge where stall_o && !hold_i; saturates at 2^CNT_W-1.
- hazard_err_o: set on an edge where, with !hold_i, a nonzero forward select points to an entry with memread = 1 and index < LOAD_READY. Cleared only by reset.

## Timing
- forward_x_o and stall_o: combinational, same cycle, from registered history plus current inputs. No pipeline latency.
- History, counter and error flag: update on the rising clk_i edge when hold_i = 0.
- Reset (rst_i = 0, asynchronous):
  - All history entries are invalid.
  - stall_cnt_o = 0 and hazard_err_o = 0.
  - As a result, forward_1_o = forward_2_o = 0. stall_o is 0 unless condition A is true on the current inputs.
- Reset mid-operation drops every in-flight producer immediately; the first post-reset cycle forwards nothing.
- Simultaneous flush_i and stall condition: flush wins, stall_o = 0, and no count.
- Simultaneous hold_i and stall: stall_o = 1, with no count and no shift.
- Source matching both entries 1 and 2: select = 1.
- rs == rt: both selects are equal.

## Test plan
- RAW, DEPTH = 2: add $3 enters EX, then two unrelated instructions follow. An EX source of 3 gives select 1 one cycle later and select 2 two cycles later; at DEPTH+1 cycles it gives 0.
- Load-use, LOAD_READY = 2: lw $5 in EX with add using $5 in ID gives stall_o = 1 for exactly 1 cycle. The following cycle, add in EX gives forward_1_o = 2, stall_cnt_o = 1, hazard_err_o = 0.
- LOAD_READY = 3, DEPTH = 3: the same lw/add sequence gives stall_o for 2 consecutive cycles, then select 3, and stall_cnt_o = 2.
- Zero register and priority: producers of $0 give select 0. Entries 1 and 2 both writing $7 with source 7 give select 1.
- hold_i and flush_i: hold asserted for 3 cycles during a stall leaves history frozen, stall_o = 1 throughout and the counter unchanged. flush_i with a load-use pattern gives stall_o = 0, and the flushed EX instruction is never forwarded.
- Error and reset: force a bubble-free lw→use in EX by driving ex_* directly, which sets hazard_err_o = 1 and keeps it set. An asynchronous rst_i pulse mid-cycle clears the flag, counter and selects immediately.
